// File: rtl/sdram_wb_arbiter.sv
// Two-port Wishbone arbiter in front of a single SDRAM controller command port.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module sdram_wb_arbiter #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [31:0]       m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_dat_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [31:0]       m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_rw,
  output logic [DATA_W-1:0] ctrl_data_in,
  output logic [3:0]        ctrl_mask,
  output logic              ctrl_in_valid,
  input  logic              ctrl_busy,
  input  logic              ctrl_out_valid,
  input  logic [DATA_W-1:0] ctrl_data_out,
  output logic [1:0]        grant_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_RD = 3'd2;
  localparam logic [2:0] S_WAIT_WR = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [3:0]        mask_q, mask_d;
  logic              valid_q, valid_d;
  logic              skip_q, skip_d;
  logic              abort_q, abort_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdat0_q, rdat0_d;
  logic [DATA_W-1:0] rdat1_q, rdat1_d;

  logic req0, req1, pick1, sel_we;
  logic own_cyc, own_req, abort_now;
  logic unused_adr;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign own_cyc = grant_q[1] ? m1_cyc_i : m0_cyc_i;
  assign own_req = grant_q[1] ? req1 : req0;
  // Once the owner lets go of cyc the transaction runs out silently.
  assign abort_now = abort_q | ~own_cyc;
  assign sel_we = pick1 ? m1_we_i : m0_we_i;
  assign unused_adr = ^{m0_adr_i[31:ADDR_W], m1_adr_i[31:ADDR_W]};

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign pick1 = ~req0;
`else
  logic rr_q, rr_d;
  assign pick1 = req1 & (~req0 | rr_q);
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdat_d  = wdat_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    skip_d  = skip_q;
    abort_d = abort_q;
    rdat0_d = rdat0_q;
    rdat1_d = rdat1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    rr_d = rr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          addr_d  = pick1 ? m1_adr_i[ADDR_W-1:0] : m0_adr_i[ADDR_W-1:0];
          rw_d    = sel_we;
          wdat_d  = pick1 ? m1_dat_i : m0_dat_i;
          mask_d  = sel_we ? (pick1 ? m1_sel_i : m0_sel_i) : 4'b0000;
          valid_d = 1'b1;
          abort_d = 1'b0;
          state_d = S_ISSUE;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
          rr_d = ~pick1;
`endif
        end
      end
      S_ISSUE: begin
        abort_d = abort_now;
        if (!ctrl_busy) begin
          valid_d = 1'b0;
          skip_d  = 1'b1;
          state_d = rw_q ? S_WAIT_WR : S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        abort_d = abort_now;
        if (ctrl_out_valid) begin
          state_d = S_ACK;
          if (!abort_now) begin
            if (grant_q[1]) rdat1_d = ctrl_data_out;
            else rdat0_d = ctrl_data_out;
            ack0_d = grant_q[0] & own_req;
            ack1_d = grant_q[1] & own_req;
          end
        end
      end
      S_WAIT_WR: begin
        abort_d = abort_now;
        // busy only rises the cycle after acceptance
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (!ctrl_busy) begin
          state_d = S_ACK;
          ack0_d = grant_q[0] & own_req & ~abort_now;
          ack1_d = grant_q[1] & own_req & ~abort_now;
        end
      end
      S_ACK: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdat_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      skip_q  <= 1'b0;
      abort_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdat0_q <= '0;
      rdat1_q <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      rr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdat_q  <= wdat_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      skip_q  <= skip_d;
      abort_q <= abort_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdat0_q <= rdat0_d;
      rdat1_q <= rdat1_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      rr_q <= rr_d;
`endif
    end
  end

  assign ctrl_addr     = addr_q;
  assign ctrl_rw       = rw_q;
  assign ctrl_data_in  = wdat_q;
  assign ctrl_mask     = mask_q;
  assign ctrl_in_valid = valid_q;
  assign grant_o       = grant_q;
  assign m0_ack_o      = ack0_q;
  assign m1_ack_o      = ack1_q;
  assign m0_dat_o      = rdat0_q;
  assign m1_dat_o      = rdat1_q;

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Bench for sdram_wb_arbiter: scripted Wishbone masters, a controller stand-in
// and a transaction-level reference of the arbitration rules.
module tb_sdram_wb_arbiter;
  localparam int AW = 23;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          gap;
    int          abort_at;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc, stb, we, ack;
  logic [3:0]  sel [2];
  logic [31:0] adr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic [AW-1:0] c_addr;
  logic        c_rw, c_iv, c_busy, c_ov;
  logic [31:0] c_din, c_dout;
  logic [3:0]  c_mask;
  logic [1:0]  grant;

  sdram_wb_arbiter #(.ADDR_W(AW), .DATA_W(32)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
    .m0_sel_i(sel[0]), .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]),
    .m0_ack_o(ack[0]), .m0_dat_o(rdat[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
    .m1_sel_i(sel[1]), .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]),
    .m1_ack_o(ack[1]), .m1_dat_o(rdat[1]),
    .ctrl_addr(c_addr), .ctrl_rw(c_rw), .ctrl_data_in(c_din),
    .ctrl_mask(c_mask), .ctrl_in_valid(c_iv), .ctrl_busy(c_busy),
    .ctrl_out_valid(c_ov), .ctrl_data_out(c_dout), .grant_o(grant)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cc = 0;
  txn_t q0[$], q1[$];
  txn_t cur [2];
  bit   mst [2];
  int   gapc [2];
  // reference transaction in flight
  bit   t_act, t_acc, t_abort, t_rd;
  int   t_own, t_start, t_end;
  logic [31:0] t_rdata;
  int   rr_m;
  logic [31:0] exp_dat [2];
  // controller stand-in
  int   e_left, e_stall;
  bit   e_rd;
  logic [31:0] e_data;
  // knobs
  int   k_lat_min, k_lat_max, k_stall_min, k_stall_max;
  bit   k_spur, k_fix;
  logic [31:0] k_data;
  // observations
  int   glog[$];
  int   n_ack [2];
  int   n_ivc, n_acc;
  logic prev_iv;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cc);
    end
  endtask

  function automatic txn_t mk(bit w, logic [31:0] a, logic [31:0] d,
                              logic [3:0] s, int gap, int ab);
    txn_t t;
    t.we = w; t.adr = a; t.dat = d; t.sel = s;
    t.gap = gap; t.abort_at = ab;
    return t;
  endfunction

  task automatic tick();
    int lat, qs, own;
    bit expiv, r0, r1;
    txn_t fr;
    @(posedge clk); #1;
    cc++;
    if (t_act && t_end >= 0 && cc == t_end + 1) begin
      t_act = 0;
      mst[t_own] = 0;
    end
    expiv = t_act && cc >= t_start && !t_acc;
    // controller
    c_ov = 1'b0;
    c_dout = $urandom;
    if (e_left > 0) begin
      c_busy = 1'b1;
      if (e_left == 1 && e_rd) begin
        c_ov = 1'b1;
        c_dout = e_data;
      end else if (!e_rd && k_spur && $urandom_range(3, 0) == 0) begin
        c_ov = 1'b1;
      end
      e_left--;
    end else begin
      if (expiv && cc == t_start) e_stall = $urandom_range(k_stall_max, k_stall_min);
      c_busy = (e_stall > 0);
      if (e_stall > 0) e_stall--;
      if (k_spur && $urandom_range(7, 0) == 0) c_ov = 1'b1;
    end
    if (expiv && !c_busy) begin
      chk("cmd_addr", c_addr, cur[t_own].adr[AW-1:0]);
      chk("cmd_rw", c_rw, cur[t_own].we);
      chk("cmd_data", c_din, cur[t_own].dat);
      chk("cmd_mask", c_mask, cur[t_own].we ? cur[t_own].sel : 4'h0);
      lat = $urandom_range(k_lat_max, k_lat_min);
      t_acc = 1;
      e_left = lat;
      e_rd = !cur[t_own].we;
      e_data = k_fix ? k_data : $urandom;
      t_rdata = e_data;
      t_end = cc + lat + (e_rd ? 1 : 2);
    end
    // masters
    for (int k = 0; k < 2; k++) begin
      qs = (k == 0) ? q0.size() : q1.size();
      if (!mst[k]) begin
        if (qs > 0) fr = (k == 0) ? q0[0] : q1[0];
        if (qs > 0 && gapc[k] >= fr.gap) begin
          if (k == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
          cur[k] = fr;
          gapc[k] = 0;
          mst[k] = 1;
          cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = fr.we;
          adr[k] = fr.adr; wdat[k] = fr.dat; sel[k] = fr.sel;
        end else begin
          if (qs > 0) gapc[k]++;
          cyc[k] = 1'b0; stb[k] = 1'($urandom_range(1, 0));
          we[k] = 1'($urandom_range(1, 0));
          adr[k] = $urandom; wdat[k] = $urandom; sel[k] = 4'($urandom);
        end
      end else if (t_act && t_own == k && cur[k].abort_at >= 0 &&
                   cc == t_start + cur[k].abort_at && (t_end < 0 || cc < t_end)) begin
        cyc[k] = 1'b0;
        stb[k] = 1'b0;
        t_abort = 1;
      end
    end
    // observations and checks for this cycle
    if (c_iv && !prev_iv) glog.push_back(grant == 2'b10 ? 1 : 0);
    if (c_iv) n_ivc++;
    if (c_iv && !c_busy) n_acc++;
    prev_iv = c_iv;
    if (t_act && t_end == cc && t_rd && !t_abort) exp_dat[t_own] = t_rdata;
    for (int k = 0; k < 2; k++) begin
      n_ack[k] += int'(ack[k]);
      chk(k ? "ack1" : "ack0", ack[k], t_act && t_own == k && t_end == cc && !t_abort);
      chk(k ? "rdat1" : "rdat0", rdat[k], exp_dat[k]);
    end
    chk("in_valid", c_iv, expiv);
    chk("grant", grant, (t_act && cc >= t_start) ? (2'b01 << t_own) : 2'b00);
    // arbitration decision for an idle cycle
    r0 = cyc[0] && stb[0];
    r1 = cyc[1] && stb[1];
    if (!t_act && (r0 || r1)) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      own = r0 ? 0 : 1;
`else
      own = (r0 && r1) ? rr_m : (r0 ? 0 : 1);
`endif
      rr_m = 1 - own;
      t_act = 1; t_own = own; t_start = cc + 1;
      t_acc = 0; t_end = -1; t_abort = 0; t_rd = !cur[own].we;
    end
  endtask

  task automatic run_idle(int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || mst[0] || mst[1] || t_act) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < budget, 1);
  endtask

  task automatic knobs(int lmin, int lmax, int smin, int smax, bit spur);
    k_lat_min = lmin; k_lat_max = lmax;
    k_stall_min = smin; k_stall_max = smax;
    k_spur = spur; k_fix = 0;
  endtask

  task automatic clear_obs();
    glog.delete();
    n_ack[0] = 0; n_ack[1] = 0;
    n_ivc = 0; n_acc = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_iv"}, c_iv, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_rdat0"}, rdat[0], 0);
    chk({tag, "_rdat1"}, rdat[1], 0);
    chk({tag, "_addr"}, c_addr, 0);
    chk({tag, "_rw"}, c_rw, 0);
    chk({tag, "_din"}, c_din, 0);
    chk({tag, "_mask"}, c_mask, 0);
  endtask

  task automatic model_reset();
    t_act = 0; t_acc = 0; t_abort = 0; t_end = -1;
    rr_m = 0; e_left = 0; e_stall = 0;
    exp_dat[0] = '0; exp_dat[1] = '0;
    mst[0] = 0; mst[1] = 0; gapc[0] = 0; gapc[1] = 0;
    cyc = '0; stb = '0; c_busy = 1'b0; c_ov = 1'b0;
    prev_iv = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    we = '0; c_dout = '0;
    for (int k = 0; k < 2; k++) begin
      sel[k] = '0; adr[k] = '0; wdat[k] = '0;
    end
    model_reset();
    knobs(1, 4, 0, 0, 0);
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // single read on port 0
    knobs(5, 5, 0, 0, 0);
    k_fix = 1; k_data = 32'hDEAD_BEEF;
    clear_obs();
    q0.push_back(mk(0, 32'h0000_0040, 32'h5555_AAAA, 4'hF, 0, -1));
    run_idle(100);
    chk("rd_dat", rdat[0], 32'hDEAD_BEEF);
    chk("rd_acks", n_ack[0], 1);

    // port 0 aborts while the read is outstanding
    knobs(5, 5, 0, 0, 0);
    k_fix = 1; k_data = 32'h0BAD_F00D;
    clear_obs();
    q0.push_back(mk(0, 32'h0000_0080, 32'h0, 4'hF, 0, 2));
    q1.push_back(mk(0, 32'h0000_00C0, 32'h0, 4'hF, 2, -1));
    run_idle(100);
    chk("abort_acks0", n_ack[0], 0);
    chk("abort_dat0", rdat[0], 32'hDEAD_BEEF);
    chk("abort_ngrants", glog.size(), 2);
    if (glog.size() == 2) chk("abort_next_grant", glog[1], 1);

    // single write on port 1
    knobs(4, 4, 0, 0, 0);
    clear_obs();
    q1.push_back(mk(1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 0, -1));
    run_idle(100);
    chk("wr_acks1", n_ack[1], 1);
    chk("wr_acks0", n_ack[0], 0);

    // both ports stream four reads each
    knobs(1, 4, 0, 0, 0);
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(0, $urandom, $urandom, 4'($urandom), 0, -1));
      q1.push_back(mk(0, $urandom, $urandom, 4'($urandom), 0, -1));
    end
    run_idle(400);
    chk("cont_ngrants", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      chk("cont_order", glog[i], i / 4);
`else
      chk("cont_order", glog[i], i % 2);
`endif
    end

    // controller busy for three cycles when the command appears
    knobs(2, 2, 3, 3, 0);
    clear_obs();
    q1.push_back(mk(0, 32'h0000_0200, 32'h0, 4'h1, 0, -1));
    run_idle(100);
    chk("stall_iv_cycles", n_ivc, 4);
    chk("stall_accepts", n_acc, 1);

    // reset while a port 0 write waits for completion
    knobs(6, 6, 0, 0, 0);
    clear_obs();
    q0.push_back(mk(1, 32'h0000_0300, 32'hCAFE_0001, 4'hF, 0, -1));
    n = 0;
    while (!t_acc && n < 20) begin
      tick();
      n++;
    end
    chk("rst_wr_accept_seen", t_acc, 1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    knobs(1, 3, 0, 0, 0);
    clear_obs();
    q1.push_back(mk(0, 32'h0000_0400, 32'h0, 4'hF, 0, -1));
    q0.push_back(mk(0, 32'h0000_0500, 32'h0, 4'hF, 0, -1));
    run_idle(100);
    chk("postrst_ngrants", glog.size(), 2);
    if (glog.size() > 0) chk("postrst_first", glog[0], 0);

    // randomized mixed traffic
    knobs(1, 6, 0, 3, 1);
    clear_obs();
    for (int i = 0; i < 40; i++) begin
      q0.push_back(mk(1'($urandom_range(1, 0)), $urandom, $urandom, 4'($urandom),
                      $urandom_range(3, 0),
                      ($urandom_range(5, 0) == 0) ? int'($urandom_range(6, 0)) : -1));
      q1.push_back(mk(1'($urandom_range(1, 0)), $urandom, $urandom, 4'($urandom),
                      $urandom_range(3, 0),
                      ($urandom_range(5, 0) == 0) ? int'($urandom_range(6, 0)) : -1));
    end
    run_idle(6000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sdram_wb_arbiter.md
# sdram_wb_arbiter

Two-port Wishbone arbiter that shares the single `sdram_controller` command interface between two bus requesters: port 0, the management-SoC Wishbone slave path, and port 1, a user accelerator/DMA master. It sits between the Wishbone slaves and `sdram_controller`. It serialises one transaction at a time, latches address, data and byte mask at grant, and pulses a per-port Wishbone ack. Default arbitration is round-robin.

## Interface
- `ADDR_W`, 23: controller address width; requester `adr[ADDR_W-1:0]` is forwarded, upper bits ignored.
- `DATA_W`, 32: data width.
- `wb_clk_i` in 1: single clock; all logic on rising edge.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: port 0 Wishbone cycle, strobe and write enable.
- `m0_sel_i` in 4; `m0_adr_i` in 32; `m0_dat_i` in DATA_W: port 0 byte select, address and write data.
- `m0_ack_o` out 1; `m0_dat_o` out DATA_W: port 0 ack and read data.
- `m1_*`: identical set for port 1.
- `ctrl_addr` out ADDR_W; `ctrl_rw` out 1 (1 = write); `ctrl_data_in` out DATA_W; `ctrl_mask` out 4.
- `ctrl_in_valid` out 1: command valid; held until accepted.
- `ctrl_busy` in 1: controller busy. Rises the cycle after a command is accepted and stays high until that command completes.
- `ctrl_out_valid` in 1; `ctrl_data_out` in DATA_W: read data strobe and read data.
- `grant_o` out 2: one-hot owner of the current transaction; 0 when idle.

## Operation
- Request from port k: `mk_cyc_i && mk_stb_i`.
- FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR, ACK.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesting: grant the port indicated by round-robin pointer `rr`.
  - On grant: latch adr/we/sel/dat into the `ctrl_*` registers, set `grant_o`, set `rr` to the non-granted port, go to ISSUE.
- ISSUE:
  - `ctrl_in_valid`=1.
  - The command is accepted on a cycle with `ctrl_busy`=0. On acceptance, drop `ctrl_in_valid` and go to WAIT_WR if write, else WAIT_RD.
- WAIT_RD: on `ctrl_out_valid`=1, latch `ctrl_data_out` into `mk_dat_o` of the granted port, go to ACK.
- WAIT_WR:
  - The first cycle after acceptance is ignored, to allow `ctrl_busy` to rise.
  - After that, `ctrl_busy`=0 means the write is done: go to ACK.
- ACK: `mk_ack_o`=1 for exactly one cycle on the granted port if it still requests; then clear `grant_o` and go to IDLE.
- Abort: if the granted requester drops `cyc` after grant, the controller transaction still completes (no partial command). Ack is suppressed and read data is not latched.
- `ctrl_mask` = sel for writes, 4'b0000 for reads.
- Ungranted port: ack stays 0 and its inputs are ignored until granted.

## Timing
- Reset (async assert, sync release) sets all outputs to 0: `ctrl_*`, `mk_ack_o`, `mk_dat_o`, `grant_o`. It also sets FSM=IDLE and `rr`=0 (port 0 first).
- Reset mid-transaction abandons the transaction with no ack. The controller is reset by the same `wb_rst_i`.
- Latency, read:
  - Request seen in IDLE at cycle N → `ctrl_in_valid` at N+1.
  - With `ctrl_busy`=0, accepted at N+1.
  - `ctrl_out_valid` at cycle R → `mk_ack_o` at R+1.
- Latency, write: accepted at N+1 → busy falls at cycle W → ack at W+1.
- Back-to-back: IDLE occupies one cycle between transactions, so the minimum request-to-request spacing is ACK+IDLE.
- Simultaneous requests in the same cycle alternate grants: 0,1,0,1 with `rr`=0 at reset.
- `ctrl_out_valid` outside WAIT_RD is ignored.

## Configuration
- `SDRAM_ARB_FIXED_PRIO_EN`: when defined, port 0 always wins simultaneous requests and `rr` is not implemented. Port 1 is served only when port 0 is idle in IDLE.
- Undefined (default): round-robin as above.

## Test plan
- Single read, port 0:
  - Stimulus: adr=0x0000_0040; controller returns 0xDEAD_BEEF with `ctrl_out_valid` 5 cycles after accept.
  - Required: `ctrl_in_valid` one cycle after request; `m0_ack_o` one cycle after `ctrl_out_valid`; `m0_dat_o`=0xDEAD_BEEF; `ctrl_mask`=0.
- Single write, port 1:
  - Stimulus: adr=0x0000_0100, dat=0x1234_5678, sel=4'b0011.
  - Required: `ctrl_rw`=1, `ctrl_mask`=4'b0011, `ctrl_addr`=0x100; `m1_ack_o` exactly once, the cycle after `ctrl_busy` falls.
- Contention: both ports issue 4 reads each, continuously.
  - Default build required: grants 0,1,0,1,0,1,0,1.
  - With `SDRAM_ARB_FIXED_PRIO_EN`: all port 0 grants precede port 1 grants.
- Busy stall: `ctrl_busy` held high 3 cycles when ISSUE is entered → `ctrl_in_valid` stays high 4 cycles, and the command is accepted exactly once.
- Abort: port 0 drops `cyc` during WAIT_RD → no `m0_ack_o`, `m0_dat_o` unchanged. The next port 1 request is granted after `ctrl_out_valid`.
- Reset mid-write:
  - Stimulus: assert `wb_rst_i` in WAIT_WR.
  - Required: all outputs 0 immediately (asynchronous), `grant_o`=0, no ack. After release, a port 1 and port 0 simultaneous request grants port 0 first.
